// File: rtl/negabin_pkg.sv
// -----------------------------------------------------------------------------
// negabin_pkg
//   Shared definitions for the negabinary arithmetic path.
//   - state_t : converter FSM states (IDLE / CONV / DONE)
//   - OUT_W() : width of the two's-complement result for an N-digit word
//   - WGT_W() : width of the running digit weight (-2)^i, sized so that the
//               final doubling after N digits still fits without wrapping
// -----------------------------------------------------------------------------
package negabin_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int OUT_W(input int n);
        return n + 1;
    endfunction

    function automatic int WGT_W(input int n);
        return n + 2;
    endfunction

endpackage

// File: rtl/negabin_acc_step.sv
// -----------------------------------------------------------------------------
// negabin_acc_step
//   One digit of negabinary-to-binary conversion (combinational).
//   Ports:
//     acc        in  OUT_W(N)  running signed sum of processed digits
//     weight     in  WGT_W(N)  signed weight (-2)^i of the current digit
//     digit      in  1         current negabinary digit
//     acc_nxt    out OUT_W(N)  acc + (digit ? weight : 0)
//     weight_nxt out WGT_W(N)  -2 * weight
// -----------------------------------------------------------------------------
module negabin_acc_step
    import negabin_pkg::*;
#(
    parameter int N = 8
) (
    input  logic signed [OUT_W(N)-1:0] acc,
    input  logic signed [WGT_W(N)-1:0] weight,
    input  logic                       digit,
    output logic signed [OUT_W(N)-1:0] acc_nxt,
    output logic signed [WGT_W(N)-1:0] weight_nxt
);

    // Only digits 0..N-1 are ever added, whose weights fit in OUT_W bits, so
    // dropping the top weight bit loses nothing for the sum.
    logic signed [OUT_W(N)-1:0] weight_trunc;

    assign weight_trunc = weight[OUT_W(N)-1:0];
    assign acc_nxt      = digit ? (acc + weight_trunc) : acc;
    assign weight_nxt   = -(weight <<< 1);

endmodule

// File: rtl/negabin_to_twos.sv
// -----------------------------------------------------------------------------
// negabin_to_twos
//   Serial converter from an N-digit negabinary word (base -2) to an
//   (N+1)-bit two's-complement integer, one digit per clock, LSB first.
//
//   Ports:
//     clk        in   1     rising-edge clock
//     rst        in   1     synchronous active-high reset
//     in_valid   in   1     in_nega valid
//     in_ready   out  1     high only in IDLE
//     in_nega    in   N     negabinary word, bit i weighs (-2)^i
//     out_valid  out  1     out_data holds a completed result
//     out_ready  in   1     consumer accepts out_data
//     out_data   out  N+1   signed result, held after acceptance
//     busy       out  1     high in CONV or DONE
//
//   Build option:
//     NEGABIN_EARLY_EXIT_EN  when defined, CONV also ends as soon as all
//                            remaining digits are zero. Results are unchanged,
//                            only latency shrinks.
// -----------------------------------------------------------------------------
module negabin_to_twos
    import negabin_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0]        in_nega,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W(N)-1:0] out_data,
    output logic                busy
);

    localparam int OW    = OUT_W(N);
    localparam int WW    = WGT_W(N);
    localparam int CNT_W = (N > 2) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t                state;
    logic signed [OW-1:0]  acc;
    logic signed [WW-1:0]  weight;
    logic [N-1:0]          shreg;
    logic [CNT_W-1:0]      cnt;

    logic signed [OW-1:0]  acc_nxt;
    logic signed [WW-1:0]  weight_nxt;
    logic                  conv_last;

    negabin_acc_step #(
        .N (N)
    ) u_step (
        .acc        (acc),
        .weight     (weight),
        .digit      (shreg[0]),
        .acc_nxt    (acc_nxt),
        .weight_nxt (weight_nxt)
    );

    // Last CONV cycle: the digit counter reaches N-1, or (early-exit build)
    // the word left after this cycle's shift has no set digits.
    always_comb begin
        conv_last = 1'b0;
`ifdef NEGABIN_EARLY_EXIT_EN
        conv_last = (cnt == CNT_LAST) || (shreg[N-1:1] == '0);
`else
        conv_last = (cnt == CNT_LAST);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            acc       <= '0;
            weight    <= WW'(1);
            shreg     <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        shreg    <= in_nega;
                        acc      <= '0;
                        weight   <= WW'(1);
                        cnt      <= '0;
                        state    <= CONV;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CONV: begin
                    acc    <= acc_nxt;
                    weight <= weight_nxt;
                    shreg  <= shreg >> 1;
                    cnt    <= cnt + 1'b1;
                    if (conv_last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_data  <= acc_nxt;
                    end
                end
                DONE: begin
                    // Result held until taken; in_ready stays low through the
                    // acceptance cycle so the next word lands one cycle later.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_negabin_to_twos.sv
// -----------------------------------------------------------------------------
// tb_negabin_to_twos
//   Self-checking bench for negabin_to_twos (N=8). Expected values come from
//   fixed tables and from an arithmetic reference: sum of digit_i * (-2)^i.
// -----------------------------------------------------------------------------
module tb_negabin_to_twos;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_nega = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N:0]   out_data;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    negabin_to_twos #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_nega   (in_nega),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference value: plain integer sum of set digits times (-2)^i.
    function automatic logic [N:0] ref_val(input logic [N-1:0] w);
        longint v;
        logic [63:0] u;
        v = 0;
        for (int i = 0; i < N; i++)
            if (w[i]) v += (i % 2 == 1) ? -(longint'(1) << i) : (longint'(1) << i);
        u = 64'(v);
        return u[N:0];
    endfunction

    // Cycles from handshake to out_valid.
    function automatic int exp_lat(input logic [N-1:0] w);
`ifdef NEGABIN_EARLY_EXIT_EN
        int h;
        h = 0;
        for (int i = 0; i < N; i++) if (w[i]) h = i;
        return h + 2;
`else
        return N + 1;
`endif
    endfunction

    // Drive one word, return observed latency (-1 on handshake timeout) and
    // result; rdy_low tells whether in_ready was low while out_valid was high.
    task automatic convert(input logic [N-1:0] w, input int rdy_dly,
                           output int lat, output logic [N:0] data,
                           output logic rdy_low);
        int g;
        g = 0;
        in_nega  = w;
        in_valid = 1'b1;
        while (!in_ready && g < 50) begin step(); g++; end
        if (!in_ready) begin
            in_valid = 1'b0;
            lat = -1; data = 'x; rdy_low = 1'b0;
            return;
        end
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin step(); lat++; end
        data    = out_data;
        rdy_low = !in_ready;
        repeat (rdy_dly) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_nega = 8'h5A;
        for (int c = 0; c < 2; c++) begin
            step();
            n_cmp++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL reset cyc%0d: in_ready=%b out_valid=%b out_data=%h busy=%b, want 1 0 000 0",
                         c, in_ready, out_valid, out_data, busy);
            end
        end
        in_valid = 1'b0;
        rst = 1'b0;
        step();
        n_cmp++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_nocapture: busy=%b in_ready=%b, want 0 1", busy, in_ready);
        end
    endtask

    task automatic test_table();
        logic [N-1:0] w_tab [7] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h55, 8'hAA, 8'hFF};
        logic [N:0]   e_tab [7] = '{9'h000, 9'h001, 9'h1FE, 9'h1FF, 9'h055, 9'h156, 9'h1AB};
        int lat; logic [N:0] d; logic rl;
        for (int k = 0; k < 7; k++) begin
            convert(w_tab[k], 0, lat, d, rl);
            n_cmp++;
            if (d !== e_tab[k]) begin
                n_err++;
                $display("FAIL table_val %h: got %h want %h", w_tab[k], d, e_tab[k]);
            end
            n_cmp++;
            if (lat != exp_lat(w_tab[k])) begin
                n_err++;
                $display("FAIL table_lat %h: got %0d want %0d", w_tab[k], lat, exp_lat(w_tab[k]));
            end
            n_cmp++;
            if (!rl) begin
                n_err++;
                $display("FAIL table_inready_done %h: in_ready high while out_valid", w_tab[k]);
            end
        end
    endtask

    task automatic test_early_exit();
        logic [N-1:0] w_tab [3] = '{8'h00, 8'h04, 8'h80};
`ifdef NEGABIN_EARLY_EXIT_EN
        int l_tab [3] = '{2, 4, 9};
`else
        int l_tab [3] = '{9, 9, 9};
`endif
        int lat; logic [N:0] d; logic rl;
        for (int k = 0; k < 3; k++) begin
            convert(w_tab[k], 1, lat, d, rl);
            n_cmp++;
            if (lat != l_tab[k] || d !== ref_val(w_tab[k])) begin
                n_err++;
                $display("FAIL early_exit %h: lat %0d data %h, want lat %0d data %h",
                         w_tab[k], lat, d, l_tab[k], ref_val(w_tab[k]));
            end
        end
    endtask

    task automatic test_backpressure();
        int lat; int g;
        logic [N:0] held;
        in_nega = 8'h37;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        g = 0;
        while (!out_valid && g < 50) begin step(); g++; end
        held = out_data;
        n_cmp++;
        if (!out_valid || held !== ref_val(8'h37)) begin
            n_err++;
            $display("FAIL bp_first: out_valid=%b data=%h want 1 %h", out_valid, held, ref_val(8'h37));
        end
        in_nega = 8'hC3;
        for (int c = 0; c < 5; c++) begin
            in_valid = (c % 2 == 0);
            step();
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold cyc%0d: out_valid=%b data=%h in_ready=%b want 1 %h 0",
                         c, out_valid, out_data, in_ready, held);
            end
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== held) begin
            n_err++;
            $display("FAIL bp_release: in_ready=%b busy=%b out_valid=%b data=%h want 1 0 0 %h",
                     in_ready, busy, out_valid, out_data, held);
        end
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin step(); lat++; end
        n_cmp++;
        if (lat != exp_lat(8'hC3) || out_data !== ref_val(8'hC3)) begin
            n_err++;
            $display("FAIL bp_second: lat %0d data %h want %0d %h",
                     lat, out_data, exp_lat(8'hC3), ref_val(8'hC3));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        int lat; logic [N:0] d; logic rl; logic seen;
        in_nega = 8'hAA;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL abort_idle: in_ready=%b busy=%b out_valid=%b want 1 0 0",
                     in_ready, busy, out_valid);
        end
        seen = 1'b0;
        for (int c = 0; c < N + 3; c++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_err++;
            $display("FAIL abort_novalid: out_valid rose after reset, want never");
        end
        convert(8'h01, 0, lat, d, rl);
        n_cmp++;
        if (d !== 9'h001 || lat != exp_lat(8'h01)) begin
            n_err++;
            $display("FAIL abort_next: data %h lat %0d want 001 %0d", d, lat, exp_lat(8'h01));
        end
    endtask

    task automatic test_random();
        int lat; logic [N:0] d; logic rl; logic [N-1:0] w;
        int bad;
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            w = N'($urandom);
            if (k < 2) w = (k == 0) ? '0 : '1;
            convert(w, int'($urandom_range(0, 2)), lat, d, rl);
            n_cmp++;
            if (d !== ref_val(w) || lat != exp_lat(w) || !rl) begin
                n_err++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random %h: data %h lat %0d rdy_low %b want %h %0d 1",
                             w, d, lat, rl, ref_val(w), exp_lat(w));
            end
        end
    endtask

    initial begin
        test_reset();
        test_table();
        test_early_exit();
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
